// File: rtl/i2c_ball_slave.sv
// I2C write-only target that receives one 6-byte ball-state frame per hand-off
// and presents it atomically on the output bytes after a clean STOP.
module i2c_ball_slave #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h2A,
  parameter int         TIMEOUT_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] y_pos0,
  output logic [7:0] y_pos1,
  output logic [7:0] y_vel,
  output logic [7:0] gravity,
  output logic [7:0] collision,
  output logic [7:0] win_flag,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

  // synchronizer / edge-history flops; reset to the idle-bus level so no
  // spurious START/STOP is seen coming out of reset
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      byte_cnt_q, byte_cnt_d;
  logic [5:0][7:0] shadow_q, shadow_d;
  logic [5:0][7:0] dout_q, dout_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            fv_q, fv_d;
  logic            fe_q, fe_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start, stop, timeout, partial;

  // two-stage synchronizers plus previous-value registers for edge decode
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s    = scl_sync_q[1];
  assign sda_s    = sda_sync_q[1];
  assign scl_rise =  scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s &  scl_prev_q;
  assign start    = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop     = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;
  assign timeout  = (state_q != IDLE) && !scl_rise && !scl_fall && (to_cnt_q == TO_LAST);
  // a matched frame that got some, but not all, of its bytes
  assign partial  = busy_q && (byte_cnt_q != 3'd0) && (byte_cnt_q != 3'd6);

  // next-state: bus conditions first, then timeout, then per-state bit handling
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    shadow_d   = shadow_q;
    dout_d     = dout_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    fv_d       = 1'b0;
    fe_d       = 1'b0;
    to_cnt_d   = (state_q == IDLE || scl_rise || scl_fall) ? '0 : to_cnt_q + 1'b1;

    if (stop && state_q != IDLE) begin
      if (busy_q && byte_cnt_q == 3'd6) begin
        dout_d = shadow_q;
        fv_d   = 1'b1;
      end
      fe_d       = partial;
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else if (start) begin
      // START or repeated START: abandon whatever was in flight
      fe_d       = partial;
      state_d    = ADDR;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      shadow_d   = '0;
    end else if (timeout) begin
      fe_d       = busy_q;
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == ADDR) begin
              if (shift_q == {SLAVE_ADDR, 1'b0}) begin
                state_d    = ADDR_ACK;
                sda_oe_d   = 1'b1;
                busy_d     = 1'b1;
                byte_cnt_d = '0;
                shadow_d   = '0;
              end else begin
                state_d = IGNORE;
              end
            end else if (byte_cnt_q < 3'd6) begin
              for (int i = 0; i < 6; i++)
                if (byte_cnt_q == 3'(i)) shadow_d[i] = shift_q;
              byte_cnt_d = byte_cnt_q + 1'b1;
              state_d    = DATA_ACK;
              sda_oe_d   = 1'b1;
            end else begin
              // surplus byte: leave SDA released (NACK) and wait for STOP
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // ACK held low across the 9th clock, released on its falling edge
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      shadow_q   <= '0;
      dout_q     <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      fv_q       <= 1'b0;
      fe_q       <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      shadow_q   <= shadow_d;
      dout_q     <= dout_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      fv_q       <= fv_d;
      fe_q       <= fe_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign frame_valid = fv_q;
  assign frame_error = fe_q;
  assign y_pos0      = dout_q[0];
  assign y_pos1      = dout_q[1];
  assign y_vel       = dout_q[2];
  assign gravity     = dout_q[3];
  assign collision   = dout_q[4];
  assign win_flag    = dout_q[5];

endmodule

// File: tb/tb_i2c_ball_slave.sv
// Directed bench for i2c_ball_slave: bit-banged I2C master with open-drain SDA.
module tb_i2c_ball_slave;

  localparam int TO = 2000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, frame_valid, frame_error, busy;
  logic [7:0] y_pos0, y_pos1, y_vel, gravity, collision, win_flag;
  wire  sda_w = sda_m & ~sda_oe;

  int n_cmp = 0, n_bad = 0;
  int fv_cnt = 0, fe_cnt = 0;
  int fv0, fe0;
  logic oe_seen = 1'b0;
  logic [7:0] acks;
  logic a;

  i2c_ball_slave #(.SLAVE_ADDR(7'h2A), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_w), .sda_oe(sda_oe),
    .y_pos0(y_pos0), .y_pos1(y_pos1), .y_vel(y_vel), .gravity(gravity),
    .collision(collision), .win_flag(win_flag),
    .frame_valid(frame_valid), .frame_error(frame_error), .busy(busy));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_error) fe_cnt++;
    if (sda_oe) oe_seen = 1'b1;
  end

  function automatic logic [47:0] outs();
    return {y_pos0, y_pos1, y_vel, gravity, collision, win_flag};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wclk(5);
    scl = 1'b1;   wclk(5);
    sda_m = 1'b0; wclk(5);
    scl = 1'b0;   wclk(5);
  endtask

  // STOP; frame_valid must be high on exactly the third sample after SDA rises
  task automatic i2c_stop(input logic exp_fv);
    sda_m = 1'b0; wclk(5);
    scl = 1'b1;   wclk(5);
    sda_m = 1'b1; wclk(3);
    chk("fv_timing", 64'(frame_valid), 64'(exp_fv));
    wclk(10);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;  wclk(5);
    scl = 1'b1; wclk(10);
    scl = 1'b0; wclk(5);
  endtask

  task automatic ack_clk(output logic ack);
    sda_m = 1'b1; wclk(5);
    scl = 1'b1;   wclk(5);
    ack = sda_oe; wclk(5);
    scl = 1'b0;   wclk(5);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_clk(ack);
  endtask

  // START + address byte + list of data bytes; acks collected MSB-first
  task automatic frame(input logic [7:0] adr, input logic [7:0] d [], output logic [7:0] ak);
    logic k;
    ak = '0;
    i2c_start();
    send_byte({adr[6:0], 1'b0}, k);
    ak = {ak[6:0], k};
    foreach (d[i]) begin
      send_byte(d[i], k);
      ak = {ak[6:0], k};
    end
  endtask

  initial begin
    logic [7:0] d6 [];
    // reset state
    wclk(5);
    chk("rst_outs", 64'(outs()), 64'h0);
    chk("rst_oe", 64'(sda_oe), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    reset = 1'b1; wclk(5);

    // wrong address: never driven, nothing updates
    oe_seen = 1'b0; fv0 = fv_cnt; fe0 = fe_cnt;
    d6 = '{8'h01, 8'h40, 8'h05, 8'h02, 8'h01, 8'h00};
    frame(8'h2B, d6, acks);
    i2c_stop(1'b0);
    chk("bad_addr_oe", 64'(oe_seen), 64'h0);
    chk("bad_addr_outs", 64'(outs()), 64'h0);
    chk("bad_addr_fv_fe", 64'({fv_cnt - fv0, fe_cnt - fe0}), 64'h0);

    // valid frame
    fv0 = fv_cnt; fe0 = fe_cnt;
    frame(8'h2A, d6, acks);
    chk("good_acks", 64'(acks), 64'h7F);
    chk("good_busy", 64'(busy), 64'h1);
    i2c_stop(1'b1);
    chk("good_outs", 64'(outs()), 64'h0140_0502_0100);
    chk("good_fv", 64'(fv_cnt - fv0), 64'h1);
    chk("good_fe", 64'(fe_cnt - fe0), 64'h0);
    chk("good_busy_end", 64'(busy), 64'h0);

    // short frame: error, outputs keep the previous frame
    fv0 = fv_cnt; fe0 = fe_cnt;
    frame(8'h2A, '{8'hDE, 8'hAD, 8'hBE}, acks);
    i2c_stop(1'b0);
    chk("short_fe", 64'(fe_cnt - fe0), 64'h1);
    chk("short_fv", 64'(fv_cnt - fv0), 64'h0);
    chk("short_outs", 64'(outs()), 64'h0140_0502_0100);

    // seven bytes: last one NACKed, first six committed
    fv0 = fv_cnt; fe0 = fe_cnt;
    frame(8'h2A, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77}, acks);
    chk("long_acks", 64'(acks), 64'hFE);
    i2c_stop(1'b1);
    chk("long_outs", 64'(outs()), 64'h1122_3344_5566);
    chk("long_fv_fe", 64'({fv_cnt - fv0, fe_cnt - fe0}), 64'h1_0000_0000);

    // two bytes, repeated START, then a full frame
    fv0 = fv_cnt; fe0 = fe_cnt;
    frame(8'h2A, '{8'hAA, 8'hBB}, acks);
    frame(8'h2A, '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60}, acks);
    chk("rs_fe", 64'(fe_cnt - fe0), 64'h1);
    chk("rs_acks", 64'(acks), 64'h7F);
    i2c_stop(1'b1);
    chk("rs_fv", 64'(fv_cnt - fv0), 64'h1);
    chk("rs_outs", 64'(outs()), 64'h1020_3040_5060);

    // SCL stuck low mid-byte: timeout abort, then normal recovery
    fv0 = fv_cnt; fe0 = fe_cnt;
    frame(8'h2A, '{8'h99}, acks);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    wclk(TO + 20);
    chk("to_fe", 64'(fe_cnt - fe0), 64'h1);
    chk("to_busy_oe", 64'({busy, sda_oe}), 64'h0);
    chk("to_state", 64'(dut.state_q), 64'h0);
    fv0 = fv_cnt;
    frame(8'h2A, '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6}, acks);
    i2c_stop(1'b1);
    chk("to_recover_outs", 64'(outs()), 64'hA1A2_A3A4_A5A6);
    chk("to_recover_fv", 64'(fv_cnt - fv0), 64'h1);

    // reset asserted while the slave holds the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : (8'h54 >> i) & 8'h01 ? 1'b1 : 1'b0);
    sda_m = 1'b1; wclk(5);
    scl = 1'b1;   wclk(3);
    chk("ack_held", 64'(sda_oe), 64'h1);
    reset = 1'b0;
    #1;
    chk("rst_mid_oe", 64'(sda_oe), 64'h0);
    chk("rst_mid_outs", 64'(outs()), 64'h0);
    chk("rst_mid_busy", 64'(busy), 64'h0);
    wclk(3);
    scl = 1'b1; sda_m = 1'b1; wclk(5);
    reset = 1'b1; wclk(5);
    chk("rst_after", 64'({outs(), sda_oe, busy}), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // hard stop in case a task never returns
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
